// File: rtl/reversi_accel_mul_pkg.sv
// reversi_accel_mul_pkg: shared multiplier-arbiter constants (operand/product widths, core latency) and requester-ID type
package reversi_accel_mul_pkg;
  localparam int DW_IN = 16;
  localparam int DW_P = 26;
  localparam int MUL_LAT = 3;
  localparam int NREQ_DEF = 4;
  typedef logic [$clog2(NREQ_DEF)-1:0] mul_id_t;
endpackage

// File: rtl/reversi_accel_rr_arb.sv
// reversi_accel_rr_arb: NREQ-way round-robin picker; req/ptr in, onehot grant, binary winner and any out
module reversi_accel_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  winner,
  output logic            any
);
  logic [IDW-1:0] idx;
  always_comb begin
    idx = '0;
    winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      winner = req[idx] ? idx : winner;
    end
    any = |req;
    grant = any ? NREQ'(1) << winner : '0;
  end
endmodule

// File: rtl/reversi_accel_mul_arbiter.sv
// reversi_accel_mul_arbiter: round-robin sharing of one pipelined multiplier among NREQ requesters; req_valid/req_ready/req_a/req_b in, tagged rsp_valid/rsp_id/rsp_p out with rsp_ready stall, inflight/busy status
module reversi_accel_mul_arbiter
  import reversi_accel_mul_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*DW_IN-1:0]         req_a,
  input  logic [NREQ*DW_IN-1:0]         req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_id,
  output logic [DW_P-1:0]               rsp_p,
  output logic [$clog2(MUL_LAT+2)-1:0]  inflight,
  output logic                          busy
);
  localparam int IFW = $clog2(MUL_LAT + 2);
  logic ce, any, acc, rel;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] winner, rr_ptr;
  logic [MUL_LAT-1:0] vld_pipe;
  logic [IDW-1:0] id_pipe [MUL_LAT];
  logic [DW_IN-1:0] a_r, b_r;
  logic [DW_P-1:0] p_pipe [MUL_LAT-1];
  reversi_accel_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .winner(winner),
    .any(any)
  );
  assign ce = !rsp_valid | rsp_ready;
  assign acc = ce & any;
  assign rel = rsp_valid & rsp_ready;
  assign req_ready = ce ? grant : '0;
  assign rsp_valid = vld_pipe[MUL_LAT-1];
  assign rsp_id = id_pipe[MUL_LAT-1];
  assign rsp_p = p_pipe[MUL_LAT-2];
  assign busy = inflight != '0;
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < MUL_LAT; i++) id_pipe[i] <= '0;
      rr_ptr <= '0;
      inflight <= '0;
    end else begin
      if (ce) begin
        vld_pipe <= {vld_pipe[MUL_LAT-2:0], any};
        id_pipe[0] <= winner;
        for (int i = 1; i < MUL_LAT; i++) id_pipe[i] <= id_pipe[i-1];
      end
      if (acc) rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
      inflight <= inflight + IFW'(acc) - IFW'(rel);
    end
  end
  always_ff @(posedge ap_clk) begin
    if (ce) begin
      a_r <= any ? req_a[int'(winner)*DW_IN +: DW_IN] : '0;
      b_r <= any ? req_b[int'(winner)*DW_IN +: DW_IN] : '0;
      p_pipe[0] <= DW_P'((2*DW_IN)'(a_r) * (2*DW_IN)'(b_r));
      for (int i = 1; i < MUL_LAT - 1; i++) p_pipe[i] <= p_pipe[i-1];
    end
  end
endmodule

// File: tb/tb_reversi_accel_mul_arbiter.sv
// tb_reversi_accel_mul_arbiter: randomized and directed checks of the shared multiplier arbiter against a queue-based reference model
module tb_reversi_accel_mul_arbiter;
  import reversi_accel_mul_pkg::*;
  localparam int NREQ = 4;
  typedef struct {int id; logic [DW_P-1:0] p; int cnt;} ent_t;
  logic ap_clk, ap_rst_n, rsp_valid, rsp_ready, busy;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*DW_IN-1:0] req_a, req_b;
  logic [1:0] rsp_id;
  logic [DW_P-1:0] rsp_p;
  logic [$clog2(MUL_LAT+2)-1:0] inflight;
  int checks = 0, errors = 0, ptr = 0;
  ent_t q[$];
  int got_ids[$];
  logic [DW_P-1:0] got_p[$];
  logic [NREQ-1:0] last_ready;
  logic last_valid;
  logic [1:0] last_id;
  logic [DW_P-1:0] last_p, sp;
  logic [1:0] si;
  reversi_accel_mul_arbiter #(.NREQ(NREQ)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .inflight(inflight), .busy(busy)
  );
  initial begin
    ap_clk = 0;
    forever #5 ap_clk = ~ap_clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW_IN +: DW_IN] = DW_IN'($urandom);
      req_b[i*DW_IN +: DW_IN] = DW_IN'($urandom);
    end
  endtask
  task automatic cycle();
    logic ev, ece;
    logic [NREQ-1:0] eg;
    logic [31:0] full;
    int w;
    @(negedge ap_clk);
    ev = q.size() > 0 && q[0].cnt == 0;
    ece = !ev || rsp_ready;
    w = -1;
    for (int k = 0; k < NREQ; k++) if (w < 0 && req_valid[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
    eg = (ece && w >= 0) ? NREQ'(1 << w) : '0;
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      chk("rsp_p", 32'(rsp_p), 32'(q[0].p));
    end
    chk("inflight", 32'(inflight), 32'(q.size()));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    last_ready = req_ready; last_valid = rsp_valid; last_id = rsp_id; last_p = rsp_p;
    if (rsp_valid && rsp_ready) begin
      got_ids.push_back(int'(rsp_id));
      got_p.push_back(rsp_p);
    end
    if (ev && rsp_ready) void'(q.pop_front());
    if (ece) for (int i = 0; i < q.size(); i++) if (q[i].cnt > 0) q[i].cnt = q[i].cnt - 1;
    if (ece && w >= 0) begin
      full = req_a[w*DW_IN +: DW_IN] * req_b[w*DW_IN +: DW_IN];
      q.push_back('{w, full[DW_P-1:0], MUL_LAT - 1});
      ptr = (w + 1) % NREQ;
    end
    @(posedge ap_clk);
    #1;
  endtask
  task automatic reset_dut();
    req_valid = '0;
    rsp_ready = 1;
    ap_rst_n = 0;
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1;
    q.delete();
    ptr = 0;
    got_ids.delete();
    got_p.delete();
  endtask
  initial begin
    ap_rst_n = 0; req_valid = '0; rsp_ready = 1; req_a = '0; req_b = '0;
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_inflight", 32'(inflight), 0);
    reset_dut();
    req_valid = 4'b0001; req_a[15:0] = 16'd3; req_b[15:0] = 16'd5;
    cycle();
    chk("single_ready", 32'(last_ready), 32'h1);
    req_valid = '0;
    repeat (3) cycle();
    chk("single_valid", 32'(last_valid), 1);
    chk("single_id", 32'(last_id), 0);
    chk("single_p", 32'(last_p), 15);
    cycle();
    reset_dut();
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      cycle();
      chk("fair_grant", 32'(last_ready), 32'(1 << (i % 4)));
    end
    req_valid = '0;
    repeat (4) cycle();
    chk("fair_count", 32'(got_ids.size()), 8);
    for (int i = 0; i < got_ids.size(); i++) chk("fair_id", 32'(got_ids[i]), 32'(i % 4));
    reset_dut();
    req_valid = 4'hF;
    rand_ops();
    repeat (4) cycle();
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_ready", 32'(last_ready), 0);
      chk("bp_valid", 32'(last_valid), 1);
      if (i == 0) begin
        sp = last_p; si = last_id;
      end else begin
        chk("bp_p_stable", 32'(last_p), 32'(sp));
        chk("bp_id_stable", 32'(last_id), 32'(si));
      end
    end
    req_valid = '0;
    rsp_ready = 1;
    repeat (5) cycle();
    chk("bp_count", 32'(got_ids.size()), 4);
    for (int i = 0; i < got_ids.size(); i++) chk("bp_id", 32'(got_ids[i]), 32'(i));
    got_p.delete();
    req_valid = 4'b0001; req_a[15:0] = 16'hFFFF; req_b[15:0] = 16'hFFFF;
    cycle();
    req_valid = 4'b0010; req_a[31:16] = 16'h1000; req_b[31:16] = 16'h4000;
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    chk("wrap_count", 32'(got_p.size()), 2);
    if (got_p.size() == 2) begin
      chk("wrap_ffff", 32'(got_p[0]), 32'h3FE0001);
      chk("wrap_zero", 32'(got_p[1]), 0);
    end
    req_valid = 4'hF;
    rand_ops();
    repeat (3) cycle();
    req_valid = '0;
    ap_rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_inflight", 32'(inflight), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    q.delete();
    ptr = 0;
    @(negedge ap_clk);
    ap_rst_n = 1;
    @(posedge ap_clk);
    #1;
    repeat (5) cycle();
    reset_dut();
    req_valid = 4'b0100;
    rand_ops();
    cycle();
    chk("ptr_first", 32'(last_ready), 32'h4);
    req_valid = 4'b1011;
    cycle();
    chk("ptr_grant3", 32'(last_ready), 32'h8);
    cycle();
    chk("ptr_grant0", 32'(last_ready), 32'h1);
    cycle();
    chk("ptr_grant1", 32'(last_ready), 32'h2);
    req_valid = '0;
    repeat (4) cycle();
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      rand_ops();
      cycle();
    end
    req_valid = '0;
    rsp_ready = 1;
    repeat (6) cycle();
    chk("drain_inflight", 32'(inflight), 0);
    chk("drain_model", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
